// File: rtl/sd_sector_browser_pkg.sv
// Shared types and constants for the SD sector browser: FSM states,
// status characters and the page/timeout geometry.
package sd_sector_browser_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_ISSUE,
    ST_READING,
    ST_SHOW,
    ST_ERROR
  } browser_state_t;

  localparam logic [7:0] CHAR_INIT    = 8'h49;  // "I"
  localparam logic [7:0] CHAR_READING = 8'h52;  // "R"
  localparam logic [7:0] CHAR_OK      = 8'h4B;  // "K"
  localparam logic [7:0] CHAR_ERROR   = 8'h45;  // "E"
  localparam logic [7:0] CHAR_TIMEOUT = 8'h54;  // "T"

  localparam logic [3:0] PAGE_LAST = 4'd15;
  localparam int         TMO_W     = 25;

endpackage

// File: rtl/sd_sector_browser_btn_debounce.sv
// Synchronises an active-low raw button and emits one pulse per accepted press;
// a level change is accepted only after DEBOUNCE_CYCLES consecutive stable cycles.
module btn_debounce
  import sd_sector_browser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_btnN,
  output logic o_pressEv
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic             r_pressEv;
  logic [CNT_W-1:0] r_cnt;
  logic             w_level;

  assign w_level = ~r_sync2;

  // Counter measures how long the synchronised level has disagreed with the
  // accepted state; any return to the accepted state restarts the count.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= 1'b0;
      r_pressEv <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btnN;
      r_sync2   <= r_sync1;
      r_pressEv <= 1'b0;
      if (w_level != r_state) begin
        if (r_cnt == CNT_LAST) begin
          r_state   <= w_level;
          r_cnt     <= '0;
          r_pressEv <= w_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pressEv = r_pressEv;

endmodule

// File: rtl/sd_sector_browser.sv
// Sequences SD sector reads and maps next/prev buttons onto 32-byte page
// navigation within a sector, reporting progress as one ASCII status char.
module sd_sector_browser
  import sd_sector_browser_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 270000,
  parameter int          TIMEOUT_CYCLES  = 27000000,
  parameter logic [31:0] SECTOR_LAST     = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        btnNext,
  input  logic        btnPrev,
  input  logic        sdReady,
  input  logic        rdBusy,
  input  logic        rdDone,
  input  logic        rdError,
  output logic        rdReq,
  output logic [31:0] rdSector,
  output logic [3:0]  pageOffset,
  output logic        dataValid,
  output logic [7:0]  statusChar
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  browser_state_t   r_state;
  browser_state_t   w_nextState;
  logic [31:0]      r_sector;
  logic [31:0]      w_nextSector;
  logic [3:0]       r_page;
  logic [3:0]       w_nextPage;
  logic             r_valid;
  logic             w_nextValid;
  logic [7:0]       r_status;
  logic [7:0]       w_nextStatus;
  logic [TMO_W-1:0] r_tmo;
  logic             w_nextEvRaw;
  logic             w_prevEvRaw;
  logic             w_nextEv;
  logic             w_prevEv;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debNext (
    .i_clk     (clk),
    .i_rstN    (rstN),
    .i_btnN    (btnNext),
    .o_pressEv (w_nextEvRaw)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debPrev (
    .i_clk     (clk),
    .i_rstN    (rstN),
    .i_btnN    (btnPrev),
    .o_pressEv (w_prevEvRaw)
  );

  // Simultaneous presses are ambiguous, so both are discarded.
  assign w_nextEv = w_nextEvRaw & ~w_prevEvRaw;
  assign w_prevEv = w_prevEvRaw & ~w_nextEvRaw;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= ST_WAIT_INIT;
      r_sector <= '0;
      r_page   <= '0;
      r_valid  <= 1'b0;
      r_status <= CHAR_INIT;
    end else begin
      r_state  <= w_nextState;
      r_sector <= w_nextSector;
      r_page   <= w_nextPage;
      r_valid  <= w_nextValid;
      r_status <= w_nextStatus;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextSector = r_sector;
    w_nextPage   = r_page;
    w_nextValid  = r_valid;
    w_nextStatus = r_status;
    unique case (r_state)
      ST_WAIT_INIT: begin
        if (sdReady && !rdBusy) w_nextState = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_nextState = ST_READING;
      end
      ST_READING: begin
        if (rdDone) begin
          w_nextState  = ST_SHOW;
          w_nextValid  = 1'b1;
          w_nextStatus = CHAR_OK;
        end else if (rdError) begin
          w_nextState  = ST_ERROR;
          w_nextStatus = CHAR_ERROR;
        end else if (r_tmo == TMO_LAST) begin
          w_nextState  = ST_ERROR;
          w_nextStatus = CHAR_TIMEOUT;
        end
      end
      ST_SHOW: begin
        if (w_nextEv) begin
          if (r_page != PAGE_LAST) begin
            w_nextPage = r_page + 4'd1;
          end else if (r_sector < SECTOR_LAST) begin
            w_nextSector = r_sector + 32'd1;
            w_nextPage   = '0;
            w_nextState  = ST_ISSUE;
          end
        end else if (w_prevEv) begin
          if (r_page != 4'd0) begin
            w_nextPage = r_page - 4'd1;
          end else if (r_sector != 32'd0) begin
            w_nextSector = r_sector - 32'd1;
            w_nextPage   = PAGE_LAST;
            w_nextState  = ST_ISSUE;
          end
        end
      end
      ST_ERROR: begin
        if (w_nextEv || w_prevEv) w_nextState = ST_ISSUE;
      end
      default: begin
        w_nextState = ST_WAIT_INIT;
      end
    endcase
    // Every path into ISSUE invalidates the buffer and reports a read in flight.
    if (w_nextState == ST_ISSUE) begin
      w_nextValid  = 1'b0;
      w_nextStatus = CHAR_READING;
    end
  end

  // Read watchdog: saturating, parked at zero whenever no read is outstanding.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_tmo <= '0;
    end else if (r_state != ST_READING) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_MAX) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign rdReq      = (r_state == ST_ISSUE);
  assign rdSector   = r_sector;
  assign pageOffset = r_page;
  assign dataValid  = r_valid;
  assign statusChar = r_status;

endmodule

// File: tb/tb_sd_sector_browser.sv
// Directed self-checking bench for sd_sector_browser: a navigation vector
// table plus hand-written init, timeout, retry and reset-mid-read sequences.
module tb_sd_sector_browser;

  localparam int DEB = 4;
  localparam int TMO = 64;

  typedef enum int {OP_NEXT, OP_PREV, OP_BOTH} op_t;

  typedef struct {
    op_t         op;
    int          hold;
    logic [3:0]  expPage;
    logic [31:0] expSector;
    int          expReqs;
    logic [7:0]  expStatus;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        btnNext;
  logic        btnPrev;
  logic        sdReady;
  logic        rdBusy;
  logic        rdDone;
  logic        rdError;
  logic        rdReq;
  logic [31:0] rdSector;
  logic [3:0]  pageOffset;
  logic        dataValid;
  logic [7:0]  statusChar;

  int testsRun    = 0;
  int testsFailed = 0;
  int reqCount    = 0;
  int cycle       = 0;
  int lastReqCycle = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sd_sector_browser #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO),
    .SECTOR_LAST     (32'hFFFFFFFF)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .btnNext    (btnNext),
    .btnPrev    (btnPrev),
    .sdReady    (sdReady),
    .rdBusy     (rdBusy),
    .rdDone     (rdDone),
    .rdError    (rdError),
    .rdReq      (rdReq),
    .rdSector   (rdSector),
    .pageOffset (pageOffset),
    .dataValid  (dataValid),
    .statusChar (statusChar)
  );

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rdReq) begin
      reqCount     <= reqCount + 1;
      lastReqCycle <= cycle;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input op_t op, input int hold, input logic [3:0] page,
                        input logic [31:0] sector, input int reqs);
    vec_t v;
    v.op        = op;
    v.hold      = hold;
    v.expPage   = page;
    v.expSector = sector;
    v.expReqs   = reqs;
    v.expStatus = 8'h4B;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input op_t op, input int hold);
    @(negedge clk);
    if (op == OP_NEXT || op == OP_BOTH) btnNext = 1'b0;
    if (op == OP_PREV || op == OP_BOTH) btnPrev = 1'b0;
    repeat (hold) @(negedge clk);
    btnNext = 1'b1;
    btnPrev = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulseDone(input logic done, input logic err);
    @(negedge clk);
    rdDone  = done;
    rdError = err;
    @(negedge clk);
    rdDone  = 1'b0;
    rdError = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitReq(input int maxCycles, input string name);
    int startCount;
    logic seen;
    startCount = reqCount;
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      if (reqCount != startCount) seen = 1'b1;
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int base;
    int elapsed;
    logic gotT;

    rstN    = 1'b0;
    btnNext = 1'b1;
    btnPrev = 1'b1;
    sdReady = 1'b0;
    rdBusy  = 1'b0;
    rdDone  = 1'b0;
    rdError = 1'b0;

    for (int i = 1; i <= 15; i++) addVec(OP_NEXT, 8, 4'(i), 32'd0, 0);
    addVec(OP_NEXT, 8, 4'd0, 32'd1, 1);
    addVec(OP_PREV, 8, 4'd15, 32'd0, 1);
    for (int i = 14; i >= 0; i--) addVec(OP_PREV, 8, 4'(i), 32'd0, 0);
    addVec(OP_PREV, 8, 4'd0, 32'd0, 0);
    addVec(OP_PREV, 8, 4'd0, 32'd0, 0);
    for (int h = 1; h <= 3; h++) addVec(OP_NEXT, h, 4'd0, 32'd0, 0);
    addVec(OP_BOTH, 8, 4'd0, 32'd0, 0);
    for (int i = 1; i <= 15; i++) addVec(OP_NEXT, 8, 4'(i), 32'd0, 0);

    repeat (3) @(negedge clk);
    checkOutput("rst_rdReq", {31'd0, rdReq}, 32'd0);
    checkOutput("rst_rdSector", rdSector, 32'd0);
    checkOutput("rst_pageOffset", {28'd0, pageOffset}, 32'd0);
    checkOutput("rst_dataValid", {31'd0, dataValid}, 32'd0);
    checkOutput("rst_statusChar", {24'd0, statusChar}, 32'h49);
    rstN = 1'b1;

    repeat (10) @(negedge clk);
    checkOutput("init_noReq", reqCount, 0);
    checkOutput("init_status", {24'd0, statusChar}, 32'h49);
    sdReady = 1'b1;
    waitReq(10, "init_reqSeen");
    repeat (4) @(negedge clk);
    checkOutput("init_reqCount", reqCount, 1);
    checkOutput("init_sector", rdSector, 32'd0);
    checkOutput("init_statusR", {24'd0, statusChar}, 32'h52);
    pulseDone(1'b1, 1'b0);
    checkOutput("init_dataValid", {31'd0, dataValid}, 32'd1);
    checkOutput("init_statusK", {24'd0, statusChar}, 32'h4B);

    foreach (vecs[i]) begin
      base = reqCount;
      applyStimulus(vecs[i].op, vecs[i].hold);
      checkOutput($sformatf("vec%0d_reqs", i), reqCount - base, vecs[i].expReqs);
      checkOutput($sformatf("vec%0d_sector", i), rdSector, vecs[i].expSector);
      checkOutput($sformatf("vec%0d_page", i), {28'd0, pageOffset}, {28'd0, vecs[i].expPage});
      if (vecs[i].expReqs > 0) pulseDone(1'b1, 1'b0);
      checkOutput($sformatf("vec%0d_status", i), {24'd0, statusChar}, {24'd0, vecs[i].expStatus});
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, dataValid}, 32'd1);
    end

    // Page 15 of sector 0: next read is left unanswered to provoke a timeout.
    base = reqCount;
    @(negedge clk);
    btnNext = 1'b0;
    gotT = 1'b0;
    for (int i = 0; i < 200 && !gotT; i++) begin
      @(negedge clk);
      if (i == 8) btnNext = 1'b1;
      if (statusChar == 8'h54) gotT = 1'b1;
    end
    btnNext = 1'b1;
    elapsed = cycle - lastReqCycle;
    checkOutput("tmo_seen", {31'd0, gotT}, 32'd1);
    checkOutput("tmo_reqs", reqCount - base, 1);
    checkOutput("tmo_latency", elapsed, 65);
    checkOutput("tmo_sector", rdSector, 32'd1);
    checkOutput("tmo_valid", {31'd0, dataValid}, 32'd0);
    repeat (10) @(negedge clk);

    base = reqCount;
    pulseDone(1'b1, 1'b0);
    checkOutput("stray_status", {24'd0, statusChar}, 32'h54);
    checkOutput("stray_valid", {31'd0, dataValid}, 32'd0);
    checkOutput("stray_reqs", reqCount - base, 0);

    applyStimulus(OP_NEXT, 8);
    checkOutput("retry_reqs", reqCount - base, 1);
    checkOutput("retry_sector", rdSector, 32'd1);
    checkOutput("retry_page", {28'd0, pageOffset}, 32'd0);
    pulseDone(1'b1, 1'b1);
    checkOutput("prio_status", {24'd0, statusChar}, 32'h4B);
    checkOutput("prio_valid", {31'd0, dataValid}, 32'd1);

    base = reqCount;
    applyStimulus(OP_PREV, 8);
    checkOutput("back_reqs", reqCount - base, 1);
    checkOutput("back_sector", rdSector, 32'd0);
    checkOutput("back_page", {28'd0, pageOffset}, 32'd15);
    rdBusy = 1'b1;
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_rdReq", {31'd0, rdReq}, 32'd0);
    checkOutput("midrst_sector", rdSector, 32'd0);
    checkOutput("midrst_page", {28'd0, pageOffset}, 32'd0);
    checkOutput("midrst_valid", {31'd0, dataValid}, 32'd0);
    checkOutput("midrst_status", {24'd0, statusChar}, 32'h49);
    @(negedge clk);
    rstN = 1'b1;
    base = reqCount;
    repeat (10) @(negedge clk);
    checkOutput("busy_noReq", reqCount - base, 0);
    rdBusy = 1'b0;
    waitReq(10, "busy_reqSeen");
    checkOutput("busy_sector", rdSector, 32'd0);
    checkOutput("busy_statusR", {24'd0, statusChar}, 32'h52);
    pulseDone(1'b0, 1'b1);
    checkOutput("err_status", {24'd0, statusChar}, 32'h45);
    checkOutput("err_valid", {31'd0, dataValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
